// File: rtl/sync_timing_pkg.sv
// Shared definitions for the single-axis sync timing generator.
// Phase codes are exported on the phase port.
package sync_timing_pkg;

  localparam int CW_DEFAULT = 10;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_BACK   = 2'd1,
    PH_ACTIVE = 2'd2,
    PH_FRONT  = 2'd3
  } phase_e;

endpackage

// File: rtl/advance_tick.sv
// Turns the raw advance qualifier into a one-clock tick,
// either per clock (level) or per rising edge of advance.
module advance_tick #(
  parameter bit ADV_EDGE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic advance,
  output logic tick
);

  logic prev_q;

  // Reset to 1 so an advance held high through reset gives no tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= advance;
    end
  end

  assign tick = ADV_EDGE ? (advance & ~prev_q) : advance;

endmodule

// File: rtl/sync_timing_gen.sv
// Single-axis video sync timing generator: SYNC/BACK/ACTIVE/FRONT
// phases with shadowed lengths reloaded at the period boundary.
module sync_timing_gen
  import sync_timing_pkg::*;
#(
  parameter int CW               = CW_DEFAULT,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0,
  parameter bit ADV_EDGE         = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance,
  input  logic [CW-1:0] sync_len,
  input  logic [CW-1:0] back_len,
  input  logic [CW-1:0] active_len,
  input  logic [CW-1:0] front_len,
  output logic          sync,
  output logic          active,
  output logic [CW-1:0] position,
  output logic [1:0]    phase,
  output logic          period_end
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [CW-1:0] clamp(input logic [CW-1:0] l);
    return (l == '0) ? ONE : l;
  endfunction

  logic tick;

  advance_tick #(
    .ADV_EDGE(ADV_EDGE)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .advance(advance),
    .tick   (tick)
  );

  phase_e        ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] sl_q, bl_q, al_q, fl_q;
  logic          load_q;
  logic          pe_q, pe_d;
  logic [CW-1:0] cur_len;
  logic          last;
  logic          wrap;
  logic          reload;

  always_comb begin
    cur_len = sl_q;
    unique case (ph_q)
      PH_SYNC:   cur_len = sl_q;
      PH_BACK:   cur_len = bl_q;
      PH_ACTIVE: cur_len = al_q;
      PH_FRONT:  cur_len = fl_q;
    endcase
  end

  assign last = (cnt_q == (cur_len - ONE));

  always_comb begin
    ph_d  = ph_q;
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (tick) begin
      if (last) begin
        cnt_d = '0;
        unique case (ph_q)
          PH_SYNC:   ph_d = PH_BACK;
          PH_BACK:   ph_d = PH_ACTIVE;
          PH_ACTIVE: ph_d = PH_FRONT;
          PH_FRONT:  ph_d = PH_SYNC;
        endcase
        wrap = (ph_q == PH_FRONT);
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    pe_d   = wrap;
    reload = load_q | wrap;
  end

  // Shadows reload on the wrap edge; the wrap decision used the old ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph_q   <= PH_SYNC;
      cnt_q  <= '0;
      sl_q   <= ONE;
      bl_q   <= ONE;
      al_q   <= ONE;
      fl_q   <= ONE;
      load_q <= 1'b1;
      pe_q   <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      pe_q   <= pe_d;
      load_q <= 1'b0;
      if (reload) begin
        sl_q <= clamp(sync_len);
        bl_q <= clamp(back_len);
        al_q <= clamp(active_len);
        fl_q <= clamp(front_len);
      end
    end
  end

  assign sync       = (ph_q == PH_SYNC) ? SYNC_ACTIVE_HIGH : ~SYNC_ACTIVE_HIGH;
  assign active     = (ph_q == PH_ACTIVE);
  assign position   = active ? cnt_q : '0;
  assign phase      = ph_q;
  assign period_end = pe_q;

endmodule

// File: tb/tb_sync_timing_gen.sv
// Directed bench: vertical (edge) and horizontal (level) instances.
module tb_sync_timing_gen;
  import sync_timing_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic       v_adv;
  logic [9:0] v_sl, v_bl, v_al, v_fl;
  logic       v_sync, v_act, v_pe;
  logic [9:0] v_pos;
  logic [1:0] v_ph;

  logic       h_adv;
  logic [9:0] h_sl, h_bl, h_al, h_fl;
  logic       h_sync, h_act, h_pe;
  logic [9:0] h_pos;
  logic [1:0] h_ph;

  sync_timing_gen #(.CW(10), .SYNC_ACTIVE_HIGH(1'b0), .ADV_EDGE(1'b1)) u_v (
    .clock(clk), .reset(rst_n), .advance(v_adv),
    .sync_len(v_sl), .back_len(v_bl), .active_len(v_al), .front_len(v_fl),
    .sync(v_sync), .active(v_act), .position(v_pos), .phase(v_ph),
    .period_end(v_pe)
  );

  sync_timing_gen #(.CW(10), .SYNC_ACTIVE_HIGH(1'b1), .ADV_EDGE(1'b0)) u_h (
    .clock(clk), .reset(rst_n), .advance(h_adv),
    .sync_len(h_sl), .back_len(h_bl), .active_len(h_al), .front_len(h_fl),
    .sync(h_sync), .active(h_act), .position(h_pos), .phase(h_ph),
    .period_end(h_pe)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       adv;
    logic [9:0] alen;
    logic [1:0] ph;
    int         pos;
    logic       pe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic a, int al, logic [1:0] p, int pos, logic pe);
    vec_t v;
    v.adv = a; v.alen = 10'(al); v.ph = p; v.pos = pos; v.pe = pe;
    return v;
  endfunction

  task automatic h_check(input string nm, input logic [1:0] p, input int pos,
                         input logic pe);
    chk({nm, "_phase"}, int'(h_ph), int'(p));
    chk({nm, "_sync"}, int'(h_sync), int'(p == PH_SYNC));
    chk({nm, "_active"}, int'(h_act), int'(p == PH_ACTIVE));
    chk({nm, "_pos"}, int'(h_pos), pos);
    chk({nm, "_pe"}, int'(h_pe), int'(pe));
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      h_adv = tbl[i].adv;
      h_al  = tbl[i].alen;
      @(posedge clk);
      #1;
      h_check($sformatf("%s[%0d]", nm, i), tbl[i].ph, tbl[i].pos, tbl[i].pe);
    end
  endtask

  task automatic h_restart(input int s, input int b, input int a, input int f);
    rst_n = 1'b0;
    h_sl = 10'(s); h_bl = 10'(b); h_al = 10'(a); h_fl = 10'(f);
    h_adv = 1'b1;
    @(posedge clk);
    #1;
    h_check("h_rst", PH_SYNC, 0, 1'b0);
    rst_n = 1'b1;
    tbl.delete();
  endtask

  // Vertical reference: 12-tick period S2 B3 A5 F2.
  int   vclk = 0;
  int   vidx = 0;
  logic vprev = 1'b1;
  logic vpe = 1'b0;
  int   last_pe = -1;
  int   npe = 0;

  function automatic logic [1:0] ph_of(int idx);
    if (idx < 2) return PH_SYNC;
    if (idx < 5) return PH_BACK;
    if (idx < 10) return PH_ACTIVE;
    return PH_FRONT;
  endfunction

  task automatic v_check(input string nm);
    logic [1:0] p;
    p = ph_of(vidx);
    chk({nm, "_phase"}, int'(v_ph), int'(p));
    chk({nm, "_sync"}, int'(v_sync), int'(p != PH_SYNC));
    chk({nm, "_active"}, int'(v_act), int'(p == PH_ACTIVE));
    chk({nm, "_pos"}, int'(v_pos), (p == PH_ACTIVE) ? vidx - 5 : 0);
    chk({nm, "_pe"}, int'(v_pe), int'(vpe));
  endtask

  task automatic v_step();
    logic tk;
    v_adv = ((vclk / 6) % 2) == 1;
    @(posedge clk);
    vclk++;
    vpe = 1'b0;
    if (!rst_n) begin
      vidx  = 0;
      vprev = 1'b1;
    end else begin
      tk    = v_adv & ~vprev;
      vprev = v_adv;
      if (tk) begin
        vidx = (vidx + 1) % 12;
        vpe  = (vidx == 0);
      end
    end
    #1;
    v_check("v");
    if (v_pe) begin
      if (last_pe >= 0) chk("v_pe_spacing", vclk - last_pe, 144);
      last_pe = vclk;
      npe++;
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    v_adv = 1'b0;
    v_sl = 10'd2; v_bl = 10'd3; v_al = 10'd5; v_fl = 10'd2;
    h_adv = 1'b0;
    h_sl = 10'd1; h_bl = 10'd1; h_al = 10'd4; h_fl = 10'd1;
    #2;
    v_check("v_rst0");
    h_check("h_rst0", PH_SYNC, 0, 1'b0);

    // Vertical: reset for 6 clocks, then two-plus periods.
    for (int i = 0; i < 6; i++) v_step();
    rst_n = 1'b1;
    for (int i = 0; i < 330; i++) v_step();
    chk("v_pe_seen", int'(npe >= 2), 1);

    // Reset in mid-ACTIVE at position 3.
    guard = 0;
    while (vidx != 8 && guard < 200) begin
      v_step();
      guard++;
    end
    chk("v_reach_pos3", int'(v_pos), 3);
    rst_n = 1'b0;
    vidx = 0; vprev = 1'b1; vpe = 1'b0;
    #1;
    v_check("v_async_rst");
    v_step();
    v_step();
    rst_n = 1'b1;
    last_pe = -1;
    npe = 0;
    for (int i = 0; i < 170; i++) v_step();
    chk("v_pe_after_rst", npe, 1);

    // Horizontal S1 B1 A4 F1, with advance gaps.
    h_restart(1, 1, 4, 1);
    tbl.push_back(mk(1, 4, PH_BACK, 0, 0));
    tbl.push_back(mk(1, 4, PH_ACTIVE, 0, 0));
    tbl.push_back(mk(1, 4, PH_ACTIVE, 1, 0));
    tbl.push_back(mk(1, 4, PH_ACTIVE, 2, 0));
    tbl.push_back(mk(1, 4, PH_ACTIVE, 3, 0));
    tbl.push_back(mk(1, 4, PH_FRONT, 0, 0));
    tbl.push_back(mk(1, 4, PH_SYNC, 0, 1));
    tbl.push_back(mk(0, 4, PH_SYNC, 0, 0));
    tbl.push_back(mk(0, 4, PH_SYNC, 0, 0));
    tbl.push_back(mk(1, 4, PH_BACK, 0, 0));
    tbl.push_back(mk(1, 4, PH_ACTIVE, 0, 0));
    tbl.push_back(mk(0, 4, PH_ACTIVE, 0, 0));
    tbl.push_back(mk(1, 4, PH_ACTIVE, 1, 0));
    tbl.push_back(mk(1, 4, PH_ACTIVE, 2, 0));
    tbl.push_back(mk(1, 4, PH_ACTIVE, 3, 0));
    tbl.push_back(mk(1, 4, PH_FRONT, 0, 0));
    tbl.push_back(mk(1, 4, PH_SYNC, 0, 1));
    tbl.push_back(mk(1, 4, PH_BACK, 0, 0));
    run_tbl("h_basic");

    // Zero lengths behave as one.
    h_restart(0, 2, 3, 0);
    for (int p = 0; p < 2; p++) begin
      tbl.push_back(mk(1, 3, PH_BACK, 0, 0));
      tbl.push_back(mk(1, 3, PH_BACK, 0, 0));
      tbl.push_back(mk(1, 3, PH_ACTIVE, 0, 0));
      tbl.push_back(mk(1, 3, PH_ACTIVE, 1, 0));
      tbl.push_back(mk(1, 3, PH_ACTIVE, 2, 0));
      tbl.push_back(mk(1, 3, PH_FRONT, 0, 0));
      tbl.push_back(mk(1, 3, PH_SYNC, 0, 1));
    end
    run_tbl("h_zero");

    // active_len 5 -> 3 in mid-ACTIVE takes effect next period.
    h_restart(1, 1, 5, 1);
    tbl.push_back(mk(1, 5, PH_BACK, 0, 0));
    tbl.push_back(mk(1, 5, PH_ACTIVE, 0, 0));
    tbl.push_back(mk(1, 5, PH_ACTIVE, 1, 0));
    tbl.push_back(mk(1, 3, PH_ACTIVE, 2, 0));
    tbl.push_back(mk(1, 3, PH_ACTIVE, 3, 0));
    tbl.push_back(mk(1, 3, PH_ACTIVE, 4, 0));
    tbl.push_back(mk(1, 3, PH_FRONT, 0, 0));
    tbl.push_back(mk(1, 3, PH_SYNC, 0, 1));
    tbl.push_back(mk(1, 3, PH_BACK, 0, 0));
    tbl.push_back(mk(1, 3, PH_ACTIVE, 0, 0));
    tbl.push_back(mk(1, 3, PH_ACTIVE, 1, 0));
    tbl.push_back(mk(1, 3, PH_ACTIVE, 2, 0));
    tbl.push_back(mk(1, 3, PH_FRONT, 0, 0));
    tbl.push_back(mk(1, 3, PH_SYNC, 0, 1));
    tbl.push_back(mk(1, 3, PH_BACK, 0, 0));
    run_tbl("h_shadow");

    // Edge mode: advance high across reset release gives no tick.
    v_adv = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("v_hold_phase", int'(v_ph), int'(PH_SYNC));
      chk("v_hold_pe", int'(v_pe), 0);
    end
    v_adv = 1'b0;
    @(posedge clk); #1;
    chk("v_fall_phase", int'(v_ph), int'(PH_SYNC));
    v_adv = 1'b1;
    @(posedge clk); #1;
    chk("v_tick1_phase", int'(v_ph), int'(PH_SYNC));
    v_adv = 1'b0;
    @(posedge clk); #1;
    chk("v_fall2_phase", int'(v_ph), int'(PH_SYNC));
    v_adv = 1'b1;
    @(posedge clk); #1;
    chk("v_tick2_phase", int'(v_ph), int'(PH_BACK));
    @(posedge clk); #1;
    chk("v_held_phase", int'(v_ph), int'(PH_BACK));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
